// File: rtl/bit_permute_sched.sv
// rtl/bit_permute_sched.sv - streaming bit permutation with shadow/active routing tables
// Each output bit copies, inverts, or forces a constant from a selected input bit.
module bit_permute_sched #(
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(WIDTH),
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_we,
  input  logic [SELW-1:0]  cfg_idx,
  input  logic [1:0]       cfg_mode,
  input  logic [SELW-1:0]  cfg_sel,
  input  logic             cfg_commit,
  output logic             cfg_ready,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic [CNTW-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

  state_t          state;
  logic [1:0]      sh_mode  [WIDTH];
  logic [SELW-1:0] sh_sel   [WIDTH];
  logic [1:0]      act_mode [WIDTH];
  logic [SELW-1:0] act_sel  [WIDTH];
  logic [WIDTH-1:0] perm;
  logic            in_xfer;
  logic            out_xfer;
  logic            cfg_ok;
  logic            cfg_wr;

  always_comb begin
    perm = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (act_mode[i])
        2'd0:    perm[i] = in_data[act_sel[i]];
        2'd1:    perm[i] = 1'b0;
        2'd2:    perm[i] = 1'b1;
        default: perm[i] = ~in_data[act_sel[i]];
      endcase
    end
  end

  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign cfg_ready = (state != SWAP);
  assign cfg_busy  = (state != RUN);
  // Range checks matter only when WIDTH is not a power of two.
  assign cfg_ok    = (32'(cfg_idx) < 32'(WIDTH)) && (32'(cfg_sel) < 32'(WIDTH));
  assign cfg_wr    = cfg_we && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        sh_mode[i]  <= 2'd0;
        sh_sel[i]   <= SELW'(i);
        act_mode[i] <= 2'd0;
        act_sel[i]  <= SELW'(i);
      end
      state   <= RUN;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !cfg_ok;
      if (cfg_wr && cfg_ok) begin
        sh_mode[cfg_idx] <= cfg_mode;
        sh_sel[cfg_idx]  <= cfg_sel;
      end
      case (state)
        RUN:     if (cfg_commit) state <= DRAIN;
        DRAIN:   if (!out_valid || out_ready) state <= SWAP;
        default: begin
          for (int i = 0; i < WIDTH; i++) begin
            act_mode[i] <= sh_mode[i];
            act_sel[i]  <= sh_sel[i];
          end
          state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= perm;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_permute_sched.sv
// tb/tb_bit_permute_sched.sv - scoreboard and vector bench for bit_permute_sched
module tb_bit_permute_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [7:0]  in_data = '0, out_data;
  logic        cfg_we = 1'b0, cfg_commit = 1'b0, cfg_ready, cfg_busy, cfg_err;
  logic [2:0]  cfg_idx = '0, cfg_sel = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] xfer_cnt;

  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [5:0]  s_in_data = '0, s_out_data;
  logic        s_cfg_we = 1'b0, s_cfg_commit = 1'b0, s_cfg_ready, s_cfg_busy, s_cfg_err;
  logic [2:0]  s_cfg_idx = '0, s_cfg_sel = '0;
  logic [1:0]  s_cfg_mode = '0;
  logic [15:0] s_xfer_cnt;

  int checks = 0;
  int failures = 0;
  int bubbles = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  bit_permute_sched #(.WIDTH(8), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
    .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .xfer_cnt(xfer_cnt)
  );

  // Non-power-of-two width so out-of-range indices are representable.
  bit_permute_sched #(.WIDTH(6), .CNTW(16)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .cfg_we(s_cfg_we), .cfg_idx(s_cfg_idx), .cfg_mode(s_cfg_mode), .cfg_sel(s_cfg_sel),
    .cfg_commit(s_cfg_commit), .cfg_ready(s_cfg_ready), .cfg_busy(s_cfg_busy), .cfg_err(s_cfg_err),
    .xfer_cnt(s_xfer_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        chk("sb_out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] e, input bit rnd);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready) break;
      bubbles++;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [1:0] mode, input logic [2:0] sel);
    cfg_we = 1'b1; cfg_idx = idx; cfg_mode = mode; cfg_sel = sel;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commit_wait();
    int n = 0;
    cfg_commit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_commit = 1'b0;
    while (cfg_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("commit_done", 32'(cfg_busy), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] held;

    vecs[0] = '{din: 8'hFF, exp: 8'hFA};
    vecs[1] = '{din: 8'h00, exp: 8'h04};
    vecs[2] = '{din: 8'h05, exp: 8'h02};
    vecs[3] = '{din: 8'hA5, exp: 8'hA2};
    vecs[4] = '{din: 8'h3C, exp: 8'h38};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Identity stream and one-cycle latency.
    out_ready = 1'b1;
    send(8'hA5, 8'hA5, 1'b0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'hA5);
    send(8'h3C, 8'h3C, 1'b0);
    @(negedge clk);
    chk("xfer_cnt_two", 32'(xfer_cnt), 32'd2);

    // Reverse table; word accepted with the commit still uses identity.
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 2'd0, 3'(7 - i));
    cfg_commit = 1'b1; in_valid = 1'b1; in_data = 8'h01;
    #1;
    chk("commit_cycle_in_ready", 32'(in_ready), 32'd1);
    sb.push_back(8'h01);
    @(posedge clk);
    @(negedge clk);
    cfg_commit = 1'b0; in_valid = 1'b0;
    n = 0;
    while (cfg_busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_ge2", 32'(n >= 2), 32'd1);
    send(8'h01, 8'h80, 1'b0);
    drain();

    // Mixed table with random backpressure.
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 2'd0, 3'(i));
    cfg_write(3'd0, 2'd1, 3'd0);
    cfg_write(3'd1, 2'd0, 3'd0);
    cfg_write(3'd2, 2'd3, 3'd2);
    commit_wait();
    for (int i = 0; i < 5; i++) send(vecs[i].din, vecs[i].exp, 1'b1);
    drain();

    // Stall in DRAIN until the output word is taken.
    out_ready = 1'b0;
    send(8'hFF, 8'hFA, 1'b0);
    cfg_commit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_commit = 1'b0;
    held = out_data;
    in_valid = 1'b1; in_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_busy", 32'(cfg_busy), 32'd1);
      chk("drain_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_hold", 32'(out_data), 32'(held));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("swap_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("swap_busy", 32'(cfg_busy), 32'd1);
    @(negedge clk);
    chk("run_after_swap", 32'(cfg_busy), 32'd0);
    drain();

    // Range errors on the 6-bit instance.
    s_cfg_we = 1'b1; s_cfg_idx = 3'd3; s_cfg_mode = 2'd0; s_cfg_sel = 3'd7;
    @(posedge clk); @(negedge clk);
    s_cfg_we = 1'b0;
    chk("err_sel_pulse", 32'(s_cfg_err), 32'd1);
    @(negedge clk);
    chk("err_sel_clear", 32'(s_cfg_err), 32'd0);
    s_cfg_we = 1'b1; s_cfg_idx = 3'd6; s_cfg_mode = 2'd2; s_cfg_sel = 3'd0;
    @(posedge clk); @(negedge clk);
    s_cfg_we = 1'b0;
    chk("err_idx_pulse", 32'(s_cfg_err), 32'd1);
    s_cfg_we = 1'b1; s_cfg_idx = 3'd0; s_cfg_mode = 2'd2; s_cfg_sel = 3'd5;
    @(posedge clk); @(negedge clk);
    s_cfg_we = 1'b0;
    chk("err_ok_write", 32'(s_cfg_err), 32'd0);
    s_cfg_commit = 1'b1;
    @(posedge clk); @(negedge clk);
    s_cfg_commit = 1'b0;
    n = 0;
    while (s_cfg_busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    s_in_valid = 1'b1; s_in_data = 6'b001000;
    @(posedge clk); @(negedge clk);
    s_in_valid = 1'b0;
    chk("small_valid", 32'(s_out_valid), 32'd1);
    chk("small_data", 32'(s_out_data), 32'h09);

    // Reset in DRAIN with a pending reverse table.
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 2'd0, 3'(7 - i));
    out_ready = 1'b0;
    send(8'h33, 8'h36, 1'b0);
    cfg_commit = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_commit = 1'b0;
    chk("pre_rst_busy", 32'(cfg_busy), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(cfg_busy), 32'd0);
    chk("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h5A, 8'h5A, 1'b0);
    commit_wait();
    send(8'h01, 8'h01, 1'b0);
    drain();

    // Full-rate stream across the counter wrap.
    do_reset();
    out_ready = 1'b1;
    bubbles = 0;
    for (int i = 0; i < 65537; i++) send(8'(i), 8'(i), 1'b0);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    drain();
    chk("xfer_cnt_wrap", 32'(xfer_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
